// File: rtl/ldpc_pkg.sv
// Shared types and default constants for the LDPC iteration controller.
package ldpc_pkg;

    // Default code geometry and pipeline depth.
    localparam int LDPC_K       = 6;
    localparam int LDPC_J       = 3;
    localparam int LDPC_L       = 32;
    localparam int LDPC_CNU_LAT = 4;

    // Cycles per decoding iteration: CNU sweep + flush, VNU sweep, one CHECK cycle.
    localparam int ITER_CYCLES = 2 * LDPC_L + LDPC_CNU_LAT + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CNU   = 3'd2,
        S_VNU   = 3'd3,
        S_CHECK = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } ldpc_state_t;

endpackage

// File: rtl/ldpc_phase_counter.sv
// Address/phase counter shared by every phase: synchronous clear, count enable,
// terminal-count flag at LIMIT-1 and wrap to zero past it.
module ldpc_phase_counter #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc_o  = (cnt_q == WIDTH'(LIMIT - 1));
    assign cnt_o = cnt_q;

    // Next count: clear wins over enable; never run past LIMIT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for a layered-schedule LDPC decoder: sequences intrinsic
// load, CNU/VNU phases, syndrome check and output drain for one frame.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int K          = LDPC_K,
    parameter int J          = LDPC_J,
    parameter int L          = LDPC_L,
    parameter int ADDR_WIDTH = 5,
    parameter int CNU_LAT    = LDPC_CNU_LAT,
    parameter int ITER_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] max_iter,
    input  logic [J*K-1:0]        p_bit,
    input  logic                  p_bit_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  load_en,
    output logic                  cnu_en,
    output logic                  vnu_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  out_valid,
    output logic                  done,
    output logic                  success,
    output logic [ITER_WIDTH-1:0] iter_count
);

    localparam int FL_W = (CNU_LAT > 1) ? $clog2(CNU_LAT) : 1;

    ldpc_state_t           state_q, state_d;
    logic                  flush_q, flush_d;
    logic [FL_W-1:0]       fl_cnt_q, fl_cnt_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic [ITER_WIDTH-1:0] max_q, max_d;
    logic                  succ_q, succ_d;
    logic                  synd_q, synd_d;
    logic                  busy_q, load_en_q, cnu_en_q, vnu_en_q, out_valid_q, done_q;
    logic                  cnt_clr, cnt_en, cnt_tc;

    ldpc_phase_counter #(
        .WIDTH (ADDR_WIDTH),
        .LIMIT (L)
    ) u_phase_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (addr),
        .tc_o  (cnt_tc)
    );

    // Next-state logic; the address counter is cleared on every phase entry.
    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        fl_cnt_d = fl_cnt_q;
        iter_d   = iter_q;
        max_d    = max_q;
        succ_d   = succ_q;
        synd_d   = synd_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_clr = 1'b1;
                    max_d   = (max_iter == '0) ? ITER_WIDTH'(1) : max_iter;
                    iter_d  = '0;
                    succ_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (cnt_tc) begin
                    state_d = S_CNU;
                    cnt_clr = 1'b1;
                    iter_d  = ITER_WIDTH'(1);
                    synd_d  = 1'b0;
                    flush_d = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_CNU: begin
                synd_d = synd_q | (p_bit_valid & (|p_bit));
                if (!flush_q) begin
                    // Address sweep; hold at L-1 once the sweep completes.
                    if (cnt_tc) begin
                        flush_d  = 1'b1;
                        fl_cnt_d = '0;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end else begin
                    // Pipeline flush before the VNU phase may read CNU results.
                    fl_cnt_d = fl_cnt_q + FL_W'(1);
                    if (fl_cnt_q == FL_W'(CNU_LAT - 1)) begin
                        state_d = S_VNU;
                        cnt_clr = 1'b1;
                        flush_d = 1'b0;
                    end
                end
            end
            S_VNU: begin
                if (cnt_tc) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_CHECK: begin
                cnt_clr = 1'b1;
                if (!synd_q) begin
                    succ_d  = 1'b1;
                    state_d = S_DRAIN;
                end else if (iter_q == max_q) begin
                    succ_d  = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    iter_d  = iter_q + ITER_WIDTH'(1);
                    synd_d  = 1'b0;
                    flush_d = 1'b0;
                    state_d = S_CNU;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (cnt_tc) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            S_DONE: begin
                cnt_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, frame registers and registered phase strobes decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            flush_q     <= 1'b0;
            fl_cnt_q    <= '0;
            iter_q      <= '0;
            max_q       <= '0;
            succ_q      <= 1'b0;
            synd_q      <= 1'b0;
            busy_q      <= 1'b0;
            load_en_q   <= 1'b0;
            cnu_en_q    <= 1'b0;
            vnu_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            fl_cnt_q    <= fl_cnt_d;
            iter_q      <= iter_d;
            max_q       <= max_d;
            succ_q      <= succ_d;
            synd_q      <= synd_d;
            busy_q      <= (state_d != S_IDLE);
            load_en_q   <= (state_d == S_LOAD);
            cnu_en_q    <= (state_d == S_CNU) && !flush_d;
            vnu_en_q    <= (state_d == S_VNU);
            out_valid_q <= (state_d == S_DRAIN);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign busy       = busy_q;
    assign load_en    = load_en_q;
    assign cnu_en     = cnu_en_q;
    assign vnu_en     = vnu_en_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign success    = succ_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Self-checking bench for ldpc_iter_ctrl: a cycle-schedule model checks every
// output each cycle, and directed frames pin latency, iteration count and drain.
module tb_ldpc_iter_ctrl;
    import ldpc_pkg::*;

    localparam int L   = LDPC_L;
    localparam int LAT = LDPC_CNU_LAT;
    localparam int IC  = ITER_CYCLES;
    localparam int JK  = LDPC_J * LDPC_K;

    logic          clk = 1'b0;
    logic          reset, start, p_bit_valid, out_ready;
    logic [4:0]    max_iter;
    logic [JK-1:0] p_bit;
    logic          busy, load_en, cnu_en, vnu_en, out_valid, done, success;
    logic [4:0]    addr, iter_count;

    ldpc_iter_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .max_iter    (max_iter),
        .p_bit       (p_bit),
        .p_bit_valid (p_bit_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .load_en     (load_en),
        .cnu_en      (cnu_en),
        .vnu_en      (vnu_en),
        .addr        (addr),
        .out_valid   (out_valid),
        .done        (done),
        .success     (success),
        .iter_count  (iter_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural schedule model ----------------
    // A frame is a timeline: cycle n=1..L is LOAD, then iterations of IC cycles
    // (L CNU sweep, LAT flush, L VNU sweep, 1 check), then a handshake-driven
    // drain of L words, then one done cycle.
    bit m_ok = 0, m_act = 0, m_done = 0, m_drain = 0, m_synd = 0, m_idle_zero = 0;
    int m_n, m_h, m_max, m_iter = 0, m_r, m_it;
    bit m_succ = 0;
    bit e_busy, e_load, e_cnu, e_vnu, e_ov, e_done, c_addr, c_res, c_itr;
    int e_addr, e_itr;

    always @(negedge clk) begin
        if (m_ok) begin
            {e_busy, e_load, e_cnu, e_vnu, e_ov, e_done} = '0;
            e_addr = 0; c_addr = 0; c_res = 0; c_itr = 0; e_itr = 0;
            if (!m_act) begin
                c_res = 1; c_addr = m_idle_zero;
            end else if (m_done) begin
                e_busy = 1; e_done = 1; c_res = 1;
            end else if (m_drain) begin
                e_busy = 1; e_ov = 1; e_addr = m_h; c_addr = 1; c_res = 1;
            end else if (m_n <= L) begin
                e_busy = 1; e_load = 1; e_addr = m_n - 1; c_addr = 1;
            end else begin
                m_r = (m_n - L - 1) % IC;
                m_it = (m_n - L - 1) / IC;
                e_busy = 1; c_itr = 1; e_itr = m_it + 1;
                if (m_r < L) begin
                    e_cnu = 1; e_addr = m_r; c_addr = 1;
                end else if (m_r < L + LAT) begin
                    e_addr = L - 1; c_addr = 1;
                end else if (m_r < 2 * L + LAT) begin
                    e_vnu = 1; e_addr = m_r - L - LAT; c_addr = 1;
                end
            end
            chk("busy", busy, e_busy);
            chk("load_en", load_en, e_load);
            chk("cnu_en", cnu_en, e_cnu);
            chk("vnu_en", vnu_en, e_vnu);
            chk("out_valid", out_valid, e_ov);
            chk("done", done, e_done);
            if (c_addr) chk("addr", addr, e_addr);
            if (c_itr) chk("iter_count_run", iter_count, e_itr);
            if (c_res) begin
                chk("success", success, m_succ);
                chk("iter_count", iter_count, m_iter);
            end
        end
        // advance the model with the inputs the next rising edge will sample
        if (reset) begin
            m_ok = 1; m_act = 0; m_done = 0; m_drain = 0; m_synd = 0;
            m_succ = 0; m_iter = 0; m_idle_zero = 1;
        end else if (m_ok) begin
            if (!m_act) begin
                if (start) begin
                    m_act = 1; m_n = 1; m_idle_zero = 0;
                    m_max = (max_iter == 0) ? 1 : int'(max_iter);
                end
            end else if (m_done) begin
                m_act = 0; m_done = 0;
            end else if (m_drain) begin
                if (out_ready) begin
                    if (m_h == L - 1) begin m_drain = 0; m_done = 1; end
                    else m_h++;
                end
            end else if (m_n <= L) begin
                m_n++; m_synd = 0;
            end else begin
                m_r = (m_n - L - 1) % IC;
                m_it = (m_n - L - 1) / IC;
                if (m_r < L + LAT && p_bit_valid && (|p_bit)) m_synd = 1;
                if (m_r == IC - 1) begin
                    if (!m_synd || (m_it + 1 == m_max)) begin
                        m_succ = !m_synd; m_iter = m_it + 1; m_drain = 1; m_h = 0;
                    end else begin
                        m_n++; m_synd = 0;
                    end
                end else begin
                    m_n++;
                end
            end
        end
    end

    // ---------------- directed frames ----------------
    int r_off, r_succ, r_iter, r_cnu, r_hs, r_dcnt;
    bit r_got;
    int r_aseq[5];
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Runs one frame from IDLE; results land in r_* (offset counted from the
    // cycle after start is sampled = 1).
    task automatic run_frame(input int mi, input logic [JK-1:0] pb, input bit toggle,
                             input bit poke_vnu);
        int k;
        bit cprev, poked, rdy;
        repeat (2) @(posedge clk);
        #1;
        r_got = 0; r_cnu = 0; r_hs = 0; r_dcnt = 0; cprev = 0; poked = 0;
        for (int i = 0; i < 5; i++) r_aseq[i] = -1;
        start = 1; max_iter = 5'(mi); p_bit = pb; p_bit_valid = 1; out_ready = 1;
        @(posedge clk);
        #1;
        k = 1;
        while (!r_got && k <= 2000) begin
            start = 0;
            if (done) begin
                r_got = 1; r_off = k; r_succ = success; r_iter = iter_count;
            end else begin
                if (cnu_en && !cprev) r_cnu++;
                cprev = cnu_en;
                if (poke_vnu && vnu_en && !poked) begin start = 1; poked = 1; end
                if (out_valid) begin
                    rdy = (toggle && r_dcnt < 4) ? pat[r_dcnt] : 1'b1;
                    out_ready = rdy;
                    if (r_dcnt < 5) r_aseq[r_dcnt] = addr;
                    if (rdy) r_hs++;
                    r_dcnt++;
                end else begin
                    out_ready = 1;
                end
                @(posedge clk);
                #1;
                k++;
            end
        end
        start = 0;
        chk("frame_done_seen", r_got, 1);
    endtask

    int cnt, kk;
    bit gd;

    initial begin
        reset = 1; start = 0; max_iter = 0; p_bit = '0; p_bit_valid = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr, 0);
        chk("rst_iter", iter_count, 0);
        reset = 0;

        // clean frame: converges in one iteration
        run_frame(4, '0, 0, 0);
        chk("clean_latency", r_off, 134);
        chk("clean_success", r_succ, 1);
        chk("clean_iter", r_iter, 1);
        chk("clean_handshakes", r_hs, 32);

        // persistent parity failure hits the limit
        run_frame(3, 18'h00001, 0, 0);
        chk("fail_latency", r_off, 272);
        chk("fail_success", r_succ, 0);
        chk("fail_iter", r_iter, 3);
        chk("fail_cnu_entries", r_cnu, 3);

        // max_iter 0 behaves as 1
        run_frame(0, 18'h20000, 0, 0);
        chk("zero_max_latency", r_off, 134);
        chk("zero_max_success", r_succ, 0);
        chk("zero_max_iter", r_iter, 1);

        // drain backpressure 1,0,0,1
        run_frame(2, '0, 1, 0);
        chk("bp_a0", r_aseq[0], 0);
        chk("bp_a1", r_aseq[1], 1);
        chk("bp_a2", r_aseq[2], 1);
        chk("bp_a3", r_aseq[3], 1);
        chk("bp_a4", r_aseq[4], 2);
        chk("bp_handshakes", r_hs, 32);
        chk("bp_latency", r_off, 136);

        // start while busy in VNU is ignored
        run_frame(1, '0, 0, 1);
        chk("poke_latency", r_off, 134);
        chk("poke_success", r_succ, 1);

        // reset in the 10th CNU cycle aborts the frame
        repeat (2) @(posedge clk);
        #1;
        start = 1; max_iter = 5; p_bit = '0; p_bit_valid = 1; out_ready = 1;
        @(posedge clk);
        #1;
        start = 0; cnt = 0; kk = 0;
        while (cnt < 10 && kk < 500) begin
            if (cnu_en) cnt++;
            if (cnt < 10) begin
                @(posedge clk);
                #1;
                kk++;
            end
        end
        chk("rst_reach_cnu", cnt, 10);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_cnu_en", cnu_en, 0);
        chk("abort_addr", addr, 0);
        gd = 0;
        repeat (300) begin
            if (done) gd = 1;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", gd, 0);

        // fresh frame after abort
        run_frame(3, '0, 0, 0);
        chk("after_abort_latency", r_off, 134);
        chk("after_abort_success", r_succ, 1);
        chk("after_abort_iter", r_iter, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
